// File: rtl/numguess_autoplayer.sv
`default_nettype none
// ============================================================================
// Module  : numguess_autoplayer
// Brief   : Binary-search auto player for the number-guessing game keypad.
//           Optional macro NUMGUESS_AUTOPLAY_GENRAND_EN adds a new-secret request.
// Revision: 1.0 - initial release
// ============================================================================
module numguess_autoplayer #(
  parameter int HOLD_CYC  = 4,
  parameter int RESP_WAIT = 8,
  parameter int MAX_GUESS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       eq,
  input  logic       lt,
  input  logic       gt,
  input  logic       outrange,
  output logic [9:0] DIP,
  output logic       enter,
  output logic       genrand,
  output logic [6:0] guess,
  output logic [6:0] lo,
  output logic [6:0] hi,
  output logic [2:0] cv,
  output logic       busy,
  output logic       found,
  output logic       fail
);

  localparam int CNT_MAX = (2 * HOLD_CYC > RESP_WAIT) ? 2 * HOLD_CYC : RESP_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RESP_LAST = CW'(RESP_WAIT - 1);
`ifdef NUMGUESS_AUTOPLAY_GENRAND_EN
  localparam logic [CW-1:0] RAND_LAST = CW'(2 * HOLD_CYC - 1);
  localparam logic [CW-1:0] HOLD_CNT  = CW'(HOLD_CYC);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef NUMGUESS_AUTOPLAY_GENRAND_EN
    S_RAND,
`endif
    S_CALC,
    S_TENS_ON,
    S_TENS_OFF,
    S_ONES_ON,
    S_ONES_OFF,
    S_ENT_ON,
    S_ENT_OFF,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [6:0]    guess_nx, lo_nx, hi_nx;
  logic [2:0]    cv_nx;
  logic          found_nx, fail_nx, up, up_nx;
  logic [9:0]    dip_nx;
  logic          enter_nx, busy_nx;
  logic [7:0]    sum;
  logic [3:0]    tens, ones;

  // Tens digit by comparing against each multiple of ten; no divider needed.
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    tens_of = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (v >= 7'(10 * t)) tens_of = 4'(t);
    end
  endfunction

  function automatic logic [9:0] key_of(input logic [3:0] d);
    key_of = (d == 4'd0) ? 10'd1 : (10'd1 << (4'd10 - d));
  endfunction

  assign sum  = {1'b0, lo} + {1'b0, hi};
  assign tens = tens_of(guess_nx);
  // Ones digit fits in 4 bits, so modulo-16 subtraction is exact.
  assign ones = guess_nx[3:0] - tens * 4'd10;

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    guess_nx = guess;
    lo_nx    = lo;
    hi_nx    = hi;
    cv_nx    = cv;
    found_nx = found;
    fail_nx  = fail;
    up_nx    = up;
    case (state)
      S_IDLE: begin
        if (start) begin
          lo_nx    = 7'd1;
          hi_nx    = 7'd99;
          cv_nx    = 3'd0;
          found_nx = 1'b0;
          fail_nx  = 1'b0;
`ifdef NUMGUESS_AUTOPLAY_GENRAND_EN
          state_nx = S_RAND;
`else
          state_nx = S_CALC;
`endif
        end
      end
`ifdef NUMGUESS_AUTOPLAY_GENRAND_EN
      S_RAND: begin
        if (cnt == RAND_LAST) state_nx = S_CALC;
        else                  cnt_nx   = cnt + CNT_ONE;
      end
`endif
      S_CALC: begin
        if ((lo > hi) || (int'(cv) >= MAX_GUESS)) begin
          fail_nx  = 1'b1;
          state_nx = S_DONE;
        end else begin
          guess_nx = sum[7:1];
          cv_nx    = cv + 3'd1;
          state_nx = S_TENS_ON;
        end
      end
      S_TENS_ON, S_TENS_OFF, S_ONES_ON, S_ONES_OFF, S_ENT_ON, S_ENT_OFF: begin
        if (cnt == HOLD_LAST) begin
          case (state)
            S_TENS_ON:  state_nx = S_TENS_OFF;
            S_TENS_OFF: state_nx = S_ONES_ON;
            S_ONES_ON:  state_nx = S_ONES_OFF;
            S_ONES_OFF: state_nx = S_ENT_ON;
            S_ENT_ON:   state_nx = S_ENT_OFF;
            default:    state_nx = S_WAIT;
          endcase
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (outrange || (lt && gt)) begin
          fail_nx  = 1'b1;
          state_nx = S_DONE;
        end else if (eq) begin
          found_nx = 1'b1;
          state_nx = S_DONE;
        end else if (lt) begin
          up_nx    = 1'b1;
          state_nx = S_UPDATE;
        end else if (gt) begin
          up_nx    = 1'b0;
          state_nx = S_UPDATE;
        end else if (cnt == RESP_LAST) begin
          fail_nx  = 1'b1;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_UPDATE: begin
        if (up) lo_nx = guess + 7'd1;
        else    hi_nx = guess - 7'd1;
        state_nx = S_CALC;
      end
      S_DONE: begin
        if (!start) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output values are derived from the next state so they register in step with it.
  always_comb begin
    dip_nx   = 10'd0;
    enter_nx = 1'b0;
    case (state_nx)
      S_TENS_ON: dip_nx   = key_of(tens);
      S_ONES_ON: dip_nx   = key_of(ones);
      S_ENT_ON:  enter_nx = 1'b1;
      default:   ;
    endcase
    busy_nx = !(state_nx inside {S_IDLE, S_DONE});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      guess <= 7'd0;
      lo    <= 7'd1;
      hi    <= 7'd99;
      cv    <= 3'd0;
      found <= 1'b0;
      fail  <= 1'b0;
      up    <= 1'b0;
      DIP   <= 10'd0;
      enter <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      guess <= guess_nx;
      lo    <= lo_nx;
      hi    <= hi_nx;
      cv    <= cv_nx;
      found <= found_nx;
      fail  <= fail_nx;
      up    <= up_nx;
      DIP   <= dip_nx;
      enter <= enter_nx;
      busy  <= busy_nx;
    end
  end

`ifdef NUMGUESS_AUTOPLAY_GENRAND_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) genrand <= 1'b0;
    else      genrand <= (state_nx == S_RAND) && (cnt_nx < HOLD_CNT);
  end
`else
  assign genrand = 1'b0;
`endif

endmodule
`default_nettype wire
